spi_byte_arbiter: RTL and testbench
===================================

SPI_BYTE_ARBITER -- requirements
Module: spi_byte_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: cycles allowed per engine phase before abort (used only with SPI_ARB_TIMEOUT_EN).
REQ-002 spi_clk  input  1  sole clock, all state updates on rising edge.
REQ-003 spi_reset  input  1  asynchronous, active-high reset.
REQ-004 req  input  2  per-requester transfer request, level, held until matching done pulse.
REQ-005 req_data0 / req_data1  input  8 each  byte to transmit for requester 0 / 1, stable while req high.
REQ-006 grant  output  2  one-hot owner of the engine, 0 when idle.
REQ-007 done  output  2  one-cycle pulse to the owner when its byte has fully shifted out.
REQ-008 spi_start  output  1  start strobe to the SPI byte engine.
REQ-009 spi_data_in  output  8  byte presented to the engine.
REQ-010 spi_busy  input  1  engine busy flag; rises the cycle after an accepted start, falls after bit 7 clock low.
REQ-011 timeout_err  output  1  sticky abort flag (present only with SPI_ARB_TIMEOUT_EN).

Function
REQ-012 The block SHALL implement states IDLE, ISSUE, WAIT_DONE, DONE.
REQ-013 IDLE: if any req bit high, the block SHALL select a requester round-robin, set grant, register its byte into spi_data_in, and enter ISSUE next cycle.
REQ-014 Round-robin: priority pointer SHALL start at requester 0 and point past the last granted requester after each DONE; with a single requester it wins every time.
REQ-015 ISSUE: spi_start SHALL be 1 and held until spi_busy is sampled 1, then the block enters WAIT_DONE with spi_start 0 on that same transition.
REQ-016 WAIT_DONE: stay until spi_busy sampled 0, then enter DONE.
REQ-017 DONE: pulse done[owner] for exactly one cycle, clear grant, advance pointer, return to IDLE; a new grant SHALL not occur before the following IDLE cycle.
REQ-018 spi_data_in SHALL stay constant from grant through DONE, independent of req_data changes.
REQ-019 Requester dropping req while granted SHALL not abort the transfer; done is still pulsed.
REQ-020 Simultaneous req on both in IDLE: pointer decides; loser waits, is served next, no starvation (max one transfer wait).
REQ-021 Latency: req high in IDLE to spi_start high = 1 cycle; spi_busy fall to done pulse = 1 cycle.
REQ-022 If spi_busy is already 1 when entering IDLE, no grant SHALL be issued until it reads 0.

Reset
REQ-023 On spi_reset high, immediately: state IDLE, grant 0, done 0, spi_start 0, spi_data_in 0, pointer 0, timeout_err 0, timeout counter 0.
REQ-024 Reset mid-transfer SHALL abandon the transfer without done; the engine is not reset by this block.

Configuration
REQ-025 Macro SPI_ARB_TIMEOUT_EN defined: a counter SHALL count cycles in ISSUE and WAIT_DONE (cleared on each state entry); reaching TIMEOUT_CYCLES sets timeout_err, deasserts spi_start, pulses done[owner], and returns to IDLE.
REQ-026 Macro undefined: no counter, no timeout_err port, ISSUE/WAIT_DONE wait indefinitely.

Structure
REQ-027 A shared package SHALL hold the state encoding constants (IDLE=0, ISSUE=1, WAIT_DONE=2, DONE=3) and the default timeout value.
REQ-028 One sub-module, spi_rr_pick, SHALL implement the 2-way round-robin selection (inputs req, pointer; output one-hot pick).

Verification
REQ-029 req=01, req_data0=8'hA5, engine model asserts busy 1 cycle after start for 96 cycles -> spi_data_in=A5, single start pulse accepted, done=01 one cycle after busy falls.
REQ-030 req=11 held, data0=8'h11, data1=8'h22 -> transfers in order 11, 22, 11, 22; grant alternates 01,10,01,10.
REQ-031 req_data0 changed from 8'h3C to 8'hFF two cycles after grant -> spi_data_in remains 3C until DONE.
REQ-032 spi_reset asserted during WAIT_DONE -> all outputs 0 same cycle, no done pulse, next req granted to requester 0.
REQ-033 With SPI_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, engine never raises busy -> spi_start drops after 16 cycles, timeout_err=1, done pulsed, back to IDLE.
REQ-034 req=10 while spi_busy stuck 1 at start -> no grant until busy reads 0, then grant=10.

Source files
------------

// File: rtl/spi_byte_arbiter_pkg.sv
// spi_byte_arbiter_pkg: state encoding and default timeout shared by the SPI byte arbiter.
package spi_byte_arbiter_pkg;
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        DONE      = 2'd3
    } arb_state_t;
    localparam int TIMEOUT_DEFAULT = 255;
endpackage

// File: rtl/spi_byte_arbiter_if.sv
// spi_byte_arbiter_if: requester and SPI engine signals of the arbiter.
// The timeout_err signal exists only when SPI_ARB_TIMEOUT_EN is defined.
interface spi_byte_arbiter_if;
    logic [1:0] req;
    logic [1:0] grant;
    logic [1:0] done;
    logic [7:0] req_data0;
    logic [7:0] req_data1;
    logic [7:0] spi_data_in;
    logic       spi_start;
    logic       spi_busy;
`ifdef SPI_ARB_TIMEOUT_EN
    logic       timeout_err;
`endif
    modport master (
`ifdef SPI_ARB_TIMEOUT_EN
        output timeout_err,
`endif
        input  req, req_data0, req_data1, spi_busy,
        output grant, done, spi_start, spi_data_in
    );
    modport slave (
`ifdef SPI_ARB_TIMEOUT_EN
        input  timeout_err,
`endif
        output req, req_data0, req_data1, spi_busy,
        input  grant, done, spi_start, spi_data_in
    );
endinterface

// File: rtl/spi_byte_arbiter_rr_pick.sv
// spi_rr_pick: 2-way round-robin selection; i_ptr names the requester with priority.
module spi_rr_pick (
    input  logic [1:0] i_req,
    input  logic       i_ptr,
    output logic [1:0] o_pick
);
    always_comb o_pick = i_ptr ? (i_req[1] ? 2'b10 : {1'b0, i_req[0]})
                               : (i_req[0] ? 2'b01 : {i_req[1], 1'b0});
endmodule

// File: rtl/spi_byte_arbiter.sv
// spi_byte_arbiter: round-robin arbitration of two byte requesters onto one SPI byte engine.
// Optional phase timeout with sticky timeout_err when SPI_ARB_TIMEOUT_EN is defined.
module spi_byte_arbiter
    import spi_byte_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input logic                spi_clk,
    input logic                spi_reset,
    spi_byte_arbiter_if.master bus
);
    arb_state_t r_state;
    logic [1:0] r_grant;
    logic [1:0] r_done;
    logic [1:0] w_pick;
    logic [7:0] r_data;
    logic       r_start;
    logic       r_ptr;
    logic       w_tmo;
`ifdef SPI_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_cnt;
    logic          r_err;
    assign w_tmo = (r_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign bus.timeout_err = r_err;
`else
    assign w_tmo = 1'b0;
`endif
    assign bus.grant       = r_grant;
    assign bus.done        = r_done;
    assign bus.spi_start   = r_start;
    assign bus.spi_data_in = r_data;

    spi_rr_pick u_pick (
        .i_req  (bus.req),
        .i_ptr  (r_ptr),
        .o_pick (w_pick)
    );

    always_ff @(posedge spi_clk or posedge spi_reset) begin
        if (spi_reset) begin
            r_state <= IDLE;
            r_grant <= 2'b00;
            r_done  <= 2'b00;
            r_start <= 1'b0;
            r_data  <= 8'h00;
            r_ptr   <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
            r_cnt   <= '0;
            r_err   <= 1'b0;
`endif
        end else begin
`ifdef SPI_ARB_TIMEOUT_EN
            // Counter runs only inside the engine phases; each phase entry below restarts it.
            if (r_state == ISSUE || r_state == WAIT_DONE) r_cnt <= r_cnt + 1'b1;
            if ((r_state == ISSUE || r_state == WAIT_DONE) && w_tmo) r_err <= 1'b1;
`endif
            case (r_state)
                IDLE: if (|bus.req && !bus.spi_busy) begin
                    r_grant <= w_pick;
                    r_data  <= w_pick[1] ? bus.req_data1 : bus.req_data0;
                    r_start <= 1'b1;
                    r_state <= ISSUE;
`ifdef SPI_ARB_TIMEOUT_EN
                    r_cnt   <= '0;
`endif
                end
                ISSUE: if (w_tmo) begin
                    r_start <= 1'b0;
                    r_done  <= r_grant;
                    r_state <= DONE;
                end else if (bus.spi_busy) begin
                    r_start <= 1'b0;
                    r_state <= WAIT_DONE;
`ifdef SPI_ARB_TIMEOUT_EN
                    r_cnt   <= '0;
`endif
                end
                WAIT_DONE: if (w_tmo || !bus.spi_busy) begin
                    r_done  <= r_grant;
                    r_state <= DONE;
                end
                DONE: begin
                    // Owner 0 finishing hands priority to requester 1 and vice versa.
                    r_ptr   <= r_grant[0];
                    r_done  <= 2'b00;
                    r_grant <= 2'b00;
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spi_byte_arbiter.sv
// tb_spi_byte_arbiter: directed self-checking bench with a simple SPI engine model.
// Define SPI_ARB_TIMEOUT_EN to also exercise the timeout path.
module tb_spi_byte_arbiter;
`ifdef SPI_ARB_TIMEOUT_EN
    localparam int TMO   = 16;
    localparam int BUSY1 = 8;
`else
    localparam int TMO   = 255;
    localparam int BUSY1 = 96;
`endif
    logic spi_clk = 1'b0;
    logic spi_reset = 1'b1;
    spi_byte_arbiter_if bus ();

    spi_byte_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .spi_clk   (spi_clk),
        .spi_reset (spi_reset),
        .bus       (bus)
    );

    always #5 spi_clk = ~spi_clk;

    int checks = 0;
    int errors = 0;
    int busy_len = 4;
    int eng_cnt = 0;
    int starts = 0;
    logic eng_en = 1'b1;
    logic eng_busy = 1'b0;
    logic stuck = 1'b0;
    logic [7:0] sent[$];

    assign bus.spi_busy = eng_busy | stuck;

    // Engine: accepts start while idle, busy from the next cycle for busy_len cycles.
    always @(posedge spi_clk) begin
        if (eng_cnt > 0) begin
            eng_cnt <= eng_cnt - 1;
            if (eng_cnt == 1) eng_busy <= 1'b0;
        end else if (eng_en && bus.spi_start) begin
            eng_busy <= 1'b1;
            eng_cnt  <= busy_len;
            starts   <= starts + 1;
            sent.push_back(bus.spi_data_in);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge spi_clk);
    endtask

    task automatic do_reset();
        spi_reset = 1'b1;
        bus.req = 2'b00;
        step(1);
        spi_reset = 1'b0;
        step(1);
    endtask

    // Returns done at its first nonzero negedge (0 if it never came) and busy at the two prior negedges.
    task automatic wait_done(output logic [1:0] d, output logic [1:0] h);
        h = 2'b00;
        for (int i = 0; i < 500; i++) begin
            if (bus.done != 2'b00) break;
            h = {h[0], bus.spi_busy};
            step(1);
        end
        d = bus.done;
    endtask

    initial begin
        logic [1:0] d;
        logic [1:0] h;
        logic saw;
        int n;
        bus.req = 2'b00;
        bus.req_data0 = 8'h00;
        bus.req_data1 = 8'h00;
        step(2);
        check("rst_grant", bus.grant, 2'b00);
        check("rst_done", bus.done, 2'b00);
        check("rst_start", bus.spi_start, 1'b0);
        check("rst_data", bus.spi_data_in, 8'h00);
        spi_reset = 1'b0;
        step(1);
`ifdef SPI_ARB_TIMEOUT_EN
        check("rst_err", bus.timeout_err, 1'b0);
        eng_en = 1'b0;
        bus.req_data0 = 8'h5A;
        bus.req = 2'b01;
        step(1);
        check("tmo_grant", bus.grant, 2'b01);
        n = 0;
        for (int i = 0; i < 40 && bus.spi_start; i++) begin
            n++;
            step(1);
        end
        check("tmo_start_cycles", n, 16);
        check("tmo_done", bus.done, 2'b01);
        check("tmo_err", bus.timeout_err, 1'b1);
        bus.req = 2'b00;
        step(1);
        check("tmo_done_clr", bus.done, 2'b00);
        check("tmo_idle_grant", bus.grant, 2'b00);
        step(1);
        check("tmo_err_sticky", bus.timeout_err, 1'b1);
        eng_en = 1'b1;
        do_reset();
        check("tmo_err_rst", bus.timeout_err, 1'b0);
`endif
        // Single requester, long busy
        busy_len = BUSY1;
        starts = 0;
        sent.delete();
        bus.req_data0 = 8'hA5;
        bus.req = 2'b01;
        step(1);
        check("t1_grant", bus.grant, 2'b01);
        check("t1_start", bus.spi_start, 1'b1);
        check("t1_data", bus.spi_data_in, 8'hA5);
        wait_done(d, h);
        check("t1_done", d, 2'b01);
        check("t1_busy_fall", h, 2'b10);
        bus.req = 2'b00;
        step(1);
        check("t1_done_pulse", bus.done, 2'b00);
        check("t1_grant_clr", bus.grant, 2'b00);
        check("t1_starts", starts, 1);
        check("t1_sent", sent[0], 8'hA5);
        // Both requesting: strict alternation from requester 0
        do_reset();
        busy_len = 4;
        sent.delete();
        bus.req_data0 = 8'h11;
        bus.req_data1 = 8'h22;
        bus.req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_done(d, h);
            check("t2_done", d, (k % 2) ? 2'b10 : 2'b01);
            check("t2_grant", bus.grant, (k % 2) ? 2'b10 : 2'b01);
            step(1);
        end
        bus.req = 2'b00;
        for (int k = 0; k < 4; k++) check("t2_sent", sent[k], (k % 2) ? 8'h22 : 8'h11);
        // Data held across req_data change and req drop
        do_reset();
        bus.req_data0 = 8'h3C;
        bus.req = 2'b01;
        step(1);
        check("t3_grant", bus.grant, 2'b01);
        step(2);
        bus.req_data0 = 8'hFF;
        bus.req = 2'b00;
        step(1);
        check("t3_data_hold", bus.spi_data_in, 8'h3C);
        wait_done(d, h);
        check("t3_done", d, 2'b01);
        check("t3_data_done", bus.spi_data_in, 8'h3C);
        step(3);
        check("t3_no_regrant", bus.grant, 2'b00);
        // Reset during WAIT_DONE clears pointer and abandons transfer
        do_reset();
        busy_len = 4;
        bus.req = 2'b01;
        wait_done(d, h);
        bus.req = 2'b00;
        step(2);
        busy_len = 20;
        bus.req_data1 = 8'h77;
        bus.req = 2'b10;
        step(1);
        check("t4_grant", bus.grant, 2'b10);
        step(2);
        check("t4_in_wait", {bus.spi_start, bus.spi_busy}, 2'b01);
        spi_reset = 1'b1;
        bus.req = 2'b00;
        #1;
        check("t4_rst_grant", bus.grant, 2'b00);
        check("t4_rst_start", bus.spi_start, 1'b0);
        check("t4_rst_data", bus.spi_data_in, 8'h00);
        step(1);
        spi_reset = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 100 && bus.spi_busy; i++) begin
            saw |= (bus.done != 2'b00);
            step(1);
        end
        check("t4_no_done", saw, 1'b0);
        check("t4_busy_end", bus.spi_busy, 1'b0);
        busy_len = 4;
        bus.req = 2'b11;
        step(1);
        check("t4_regrant", bus.grant, 2'b01);
        bus.req = 2'b00;
        wait_done(d, h);
        check("t4_done", d, 2'b01);
        // Busy already high in IDLE blocks the grant
        do_reset();
        stuck = 1'b1;
        bus.req_data1 = 8'hC3;
        bus.req = 2'b10;
        step(5);
        check("t5_no_grant", bus.grant, 2'b00);
        check("t5_no_start", bus.spi_start, 1'b0);
        stuck = 1'b0;
        step(1);
        check("t5_grant", bus.grant, 2'b10);
        check("t5_data", bus.spi_data_in, 8'hC3);
        wait_done(d, h);
        check("t5_done", d, 2'b10);
        bus.req = 2'b00;
        step(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
